// File: rtl/imuldiv_int_div_iterative.sv
// Iterative restoring divider: one quotient bit per cycle, {rem, quot} response.
// Define IMULDIV_DIV_ZERO_FASTPATH_EN to send divide-by-zero straight from IDLE to DONE.
module imuldiv_int_div_iterative #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               divreq_msg_fn,
  input  logic [NBITS-1:0]   divreq_msg_a,
  input  logic [NBITS-1:0]   divreq_msg_b,
  input  logic               divreq_val,
  output logic               divreq_rdy,
  output logic [2*NBITS-1:0] divresp_msg_result,
  output logic               divresp_val,
  input  logic               divresp_rdy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(NBITS);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    counter_q, counter_d;
  logic [NBITS-1:0] rem_q, rem_d;
  logic [NBITS-1:0] quot_q, quot_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] raw_a_q, raw_a_d;
  logic             quot_sign_q, quot_sign_d;
  logic             rem_sign_q, rem_sign_d;
  logic             div0_q, div0_d;

  logic [NBITS-1:0] abs_a, abs_b;
  logic [NBITS:0]   rem_shift, diff;
  logic [NBITS-1:0] quot_out, rem_out;

  // quot_q starts out holding |a| and its MSB feeds the partial remainder each step
  always_comb begin
    abs_a     = (divreq_msg_fn && divreq_msg_a[NBITS-1]) ? -divreq_msg_a : divreq_msg_a;
    abs_b     = (divreq_msg_fn && divreq_msg_b[NBITS-1]) ? -divreq_msg_b : divreq_msg_b;
    rem_shift = {rem_q, quot_q[NBITS-1]};
    diff      = rem_shift - {1'b0, b_q};

    state_d     = state_q;
    counter_d   = counter_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    b_d         = b_q;
    raw_a_d     = raw_a_q;
    quot_sign_d = quot_sign_q;
    rem_sign_d  = rem_sign_q;
    div0_d      = div0_q;

    case (state_q)
      IDLE: begin
        if (divreq_val) begin
          rem_d       = '0;
          quot_d      = abs_a;
          b_d         = abs_b;
          raw_a_d     = divreq_msg_a;
          quot_sign_d = divreq_msg_fn & (divreq_msg_a[NBITS-1] ^ divreq_msg_b[NBITS-1]);
          rem_sign_d  = divreq_msg_fn & divreq_msg_a[NBITS-1];
          div0_d      = (divreq_msg_b == '0);
          counter_d   = '0;
`ifdef IMULDIV_DIV_ZERO_FASTPATH_EN
          state_d     = (divreq_msg_b == '0) ? DONE : CALC;
`else
          state_d     = CALC;
`endif
        end
      end
      CALC: begin
        counter_d = counter_q + CW'(1);
        if (!diff[NBITS]) begin
          rem_d  = diff[NBITS-1:0];
          quot_d = {quot_q[NBITS-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[NBITS-1:0];
          quot_d = {quot_q[NBITS-2:0], 1'b0};
        end
        if (counter_q == CW'(NBITS-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (divresp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      b_q         <= '0;
      raw_a_q     <= '0;
      quot_sign_q <= 1'b0;
      rem_sign_q  <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      b_q         <= b_d;
      raw_a_q     <= raw_a_d;
      quot_sign_q <= quot_sign_d;
      rem_sign_q  <= rem_sign_d;
      div0_q      <= div0_d;
    end
  end

  // Result is derived only from registers that are frozen in DONE, so it holds steady
  always_comb begin
    quot_out = quot_sign_q ? -quot_q : quot_q;
    rem_out  = rem_sign_q ? -rem_q : rem_q;
    if (div0_q) begin
      quot_out = '1;
      rem_out  = raw_a_q;
    end
    divreq_rdy         = (state_q == IDLE);
    divresp_val        = (state_q == DONE);
    divresp_msg_result = divresp_val ? {rem_out, quot_out} : '0;
  end

endmodule

// File: doc/imuldiv_int_div_iterative.md
Name: imuldiv_int_div_iterative

Overview:
- Iterative 32-cycle restoring integer divider for the imuldiv unit.
- Companion to the iterative multiplier; it computes the inverse operation using the same val/rdy request/response style.
- Takes a dividend/divisor pair with a signed/unsigned function bit.
- Returns {remainder, quotient} packed in one 2*NBITS response; one transaction in flight at a time.

Parameters:
- NBITS, 32, operand width. Result width is 2*NBITS; iteration count is NBITS.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- divreq_msg_fn  input  1  0 = unsigned (divu/remu), 1 = signed (div/rem).
- divreq_msg_a  input  NBITS  dividend.
- divreq_msg_b  input  NBITS  divisor.
- divreq_val  input  1  request valid.
- divreq_rdy  output  1  request ready; high only in IDLE.
- divresp_msg_result  output  2*NBITS  {remainder[NBITS-1:0], quotient[NBITS-1:0]}.
- divresp_val  output  1  response valid; high only in DONE.
- divresp_rdy  input  1  response ready.

Behaviour:
- Reset (sync, active-high), effective next posedge:
  - state = IDLE; counter = 0; operand/remainder/quotient/sign registers = 0.
  - divresp_val = 0; divresp_msg_result = 0; divreq_rdy = 1.
- FSM states:
  - IDLE: divreq_rdy = 1. A request is accepted when divreq_val & divreq_rdy.
    - Latch |a| and |b| (two's-complement negation only when fn = 1 and the operand MSB = 1).
    - Latch quot_sign = fn & (a[MSB] ^ b[MSB]), rem_sign = fn & a[MSB], div0 = (b == 0), and raw a.
    - Go to CALC with counter = 0.
  - CALC: one iteration per cycle; the counter increments each cycle.
    - Shift {rem, quot} left by 1 and bring the next dividend bit into rem LSB.
    - Compute diff = rem - |b| with NBITS+1 bits.
    - If diff is non-negative, rem = diff and quot LSB = 1; else rem is unchanged and quot LSB = 0.
    - After the NBITS-th iteration (counter == NBITS-1), go to DONE.
  - DONE: divresp_val = 1, divreq_rdy = 0.
    - Result: quotient = quot_sign ? -quot : quot; remainder = rem_sign ? -rem : rem.
    - Go to IDLE on divresp_rdy; otherwise stay with result and val held stable.
- Latency:
  - Request accepted at cycle N gives divresp_val high at cycle N+1+NBITS (N+33 for NBITS = 32).
  - Initiation interval ≥ NBITS+2 cycles. divreq_rdy is high the cycle after the response handshake.
- Divide by zero (div0):
  - quotient = all ones and remainder = raw a, for both fn values (RISC-V semantics).
  - Takes the full-latency path unless the optional feature below is enabled.
- Signed overflow (fn = 1, a = 0x80000000, b = 0xFFFFFFFF):
  - Falls out naturally as quotient = 0x80000000, remainder = 0. No special case.
- Mid-operation reset: aborts CALC or DONE, discards the result, divresp_val = 0, back to IDLE.
- No other abort path.
- Input stability: inputs are sampled only at the accept edge. Changes to divreq_msg_* during CALC/DONE have no effect.
- divresp_msg_result is defined only while divresp_val = 1; it must not glitch while held in DONE.

Optional Feature:
- Macro: IMULDIV_DIV_ZERO_FASTPATH_EN.
- Defined: an accepted request with b == 0 skips CALC and goes IDLE→DONE directly. divresp_val is high at cycle N+1 with quotient = all ones and remainder = raw a.
- Undefined: divide-by-zero runs the full NBITS iterations with an identical result and latency N+1+NBITS.
- Non-zero divisors are unaffected either way.

Test Plan:
- Unsigned division: fn = 0, a = 100, b = 7 → result 0x00000002_0000000E; divresp_val rises exactly 33 cycles after accept.
- Signed negative dividend: fn = 1, a = 0xFFFFFFF9 (-7), b = 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Signed overflow: fn = 1, a = 0x80000000, b = 0xFFFFFFFF → result 0x00000000_80000000.
- Divide by zero: fn = 1, a = 0x12345678, b = 0 → result 0x12345678_FFFFFFFF.
  - Latency is 1 cycle with IMULDIV_DIV_ZERO_FASTPATH_EN defined, 33 without.
- Backpressure: fn = 0, a = 0xFFFFFFFF, b = 0x10 with divresp_rdy held low 5 cycles in DONE.
  - Result 0x0000000F_0FFFFFFF stays stable, divreq_rdy = 0 throughout.
  - After the handshake, divreq_rdy = 1 the next cycle.
- Reset mid-CALC at iteration 10 → next cycle divresp_val = 0, divreq_rdy = 1.
  - A following fn = 0, a = 9, b = 3 gives 0x00000000_00000003.
